// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared types and geometry helpers for the L1 data cache
package data_cache_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        IDLE,
        FILL
    } cache_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_t;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return DATA_WIDTH - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU-side and RAM-side signal bundle of the data cache
interface data_cache_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic        cpu_we;
    logic        cpu_re;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_rd;
    logic        stall;
    logic [31:0] mem_r_addr;
    logic        mem_re;
    logic [31:0] mem_rd;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_wd;
    logic        mem_we;

    // master: pipeline plus RAM (the environment around the cache)
    modport master (
        output cpu_addr, cpu_wd, cpu_we, cpu_re, cpu_size, cpu_unsigned, mem_rd,
        input  cpu_rd, stall, mem_r_addr, mem_re, mem_w_addr, mem_wd, mem_we
    );

    // slave: the cache itself
    modport slave (
        input  cpu_addr, cpu_wd, cpu_we, cpu_re, cpu_size, cpu_unsigned, mem_rd,
        output cpu_rd, stall, mem_r_addr, mem_re, mem_w_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/data_cache_load_store_align.sv
// rtl/data_cache_load_store_align.sv - byte/half lane merge for stores and extract for loads
module load_store_align
    import data_cache_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wd_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] rd_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign byte_sh = {offset_i, 3'b000};
    assign half_sh = {offset_i[1], 4'b0000};
    assign ld_byte = word_i[byte_sh +: 8];
    assign ld_half = word_i[half_sh +: 16];

    // Store merge: replace the addressed lanes; size 10/11 take the whole word
    always_comb begin
        merged_o = word_i;
        if (size_i == SZ_B) begin
            merged_o[byte_sh +: 8] = wd_i[7:0];
        end else if (size_i == SZ_H) begin
            merged_o[half_sh +: 16] = wd_i[15:0];
        end else begin
            merged_o = wd_i;
        end
    end

    // Load extract: right-align the addressed lanes and extend
    always_comb begin
        rd_o = word_i;
        if (size_i == SZ_B) begin
            rd_o = unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_i == SZ_H) begin
            rd_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through write-allocate L1 data cache
module data_cache
    import data_cache_pkg::*;
#(
    parameter int SETS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    data_cache_if.slave  bus
);

    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(SETS);

    cache_state_t state_q, state_d;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [31:0]        word_addr;
    logic               hit;
    logic               is_word;
    logic [31:0]        merged;
    logic [31:0]        extracted;

    logic        line_we;
    logic [31:0] line_data;

    logic [31:0] cpu_rd_c, mem_r_addr_c, mem_w_addr_c, mem_wd_c;
    logic        stall_c, mem_re_c, mem_we_c;

    assign addr_tag  = bus.cpu_addr[31:2+INDEX_W];
    assign addr_idx  = bus.cpu_addr[2+INDEX_W-1:2];
    assign word_addr = {bus.cpu_addr[31:2], 2'b00};
    assign hit       = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    // size 11 behaves as a word access
    assign is_word   = bus.cpu_size[1];

    load_store_align u_align (
        .word_i     (data_q[addr_idx]),
        .wd_i       (bus.cpu_wd),
        .offset_i   (bus.cpu_addr[1:0]),
        .size_i     (bus.cpu_size),
        .unsigned_i (bus.cpu_unsigned),
        .merged_o   (merged),
        .rd_o       (extracted)
    );

    // Next state and outputs; reset forces every output to its idle value
    always_comb begin
        state_d      = state_q;
        cpu_rd_c     = '0;
        stall_c      = 1'b0;
        mem_r_addr_c = '0;
        mem_re_c     = 1'b0;
        mem_w_addr_c = '0;
        mem_wd_c     = '0;
        mem_we_c     = 1'b0;
        line_we      = 1'b0;
        line_data    = '0;
        if (!rst_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_we) begin
                        // full words never need the old data, so they allocate without a fill
                        if (is_word || hit) begin
                            mem_we_c     = 1'b1;
                            mem_w_addr_c = word_addr;
                            mem_wd_c     = merged;
                            line_we      = 1'b1;
                            line_data    = merged;
                        end else begin
                            stall_c = 1'b1;
                            state_d = FILL;
                        end
                    end else if (bus.cpu_re) begin
                        if (hit) begin
                            cpu_rd_c = extracted;
                        end else begin
                            stall_c = 1'b1;
                            state_d = FILL;
                        end
                    end
                end
                FILL: begin
                    // completes even if the request was dropped meanwhile
                    stall_c      = 1'b1;
                    mem_re_c     = 1'b1;
                    mem_r_addr_c = word_addr;
                    line_we      = 1'b1;
                    line_data    = bus.mem_rd;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.cpu_rd     = cpu_rd_c;
    assign bus.stall      = stall_c;
    assign bus.mem_r_addr = mem_r_addr_c;
    assign bus.mem_re     = mem_re_c;
    assign bus.mem_w_addr = mem_w_addr_c;
    assign bus.mem_wd     = mem_wd_c;
    assign bus.mem_we     = mem_we_c;

    // State register and valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (line_we) begin
                valid_q[addr_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays hold no reset; line_we is already low during reset
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[addr_idx]  <= addr_tag;
            data_q[addr_idx] <= line_data;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;

    logic clk;
    logic rst_n;
    logic [31:0] ram_word;
    int n_cmp;
    int n_mis;

    data_cache_if bus ();

    data_cache #(.SETS(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rd = ram_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] size, input logic uns);
        bus.cpu_we       = we;
        bus.cpu_re       = re;
        bus.cpu_addr     = addr;
        bus.cpu_wd       = wd;
        bus.cpu_size     = size;
        bus.cpu_unsigned = uns;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        ram_word = 32'hDEADBEEF;
        rst_n    = 1'b0;
        req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
        step();
        // reset state, with a load request presented while in reset
        req(1'b0, 1'b1, 32'h0001_0000, 32'h0, 2'b10, 1'b0);
        check_eq("rst_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("rst_mem_re", {31'h0, bus.mem_re}, 32'h0);
        check_eq("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check_eq("rst_cpu_rd", bus.cpu_rd, 32'h0);

        // 1: cold miss then fill
        rst_n = 1'b1;
        #1;
        check_eq("miss_stall", {31'h0, bus.stall}, 32'h1);
        check_eq("miss_mem_re", {31'h0, bus.mem_re}, 32'h0);
        step();
        check_eq("fill_stall", {31'h0, bus.stall}, 32'h1);
        check_eq("fill_mem_re", {31'h0, bus.mem_re}, 32'h1);
        check_eq("fill_r_addr", bus.mem_r_addr, 32'h0001_0000);
        check_eq("fill_mem_we", {31'h0, bus.mem_we}, 32'h0);
        step();
        check_eq("retry_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("retry_rd", bus.cpu_rd, 32'hDEADBEEF);

        // 2: repeat hit
        step();
        check_eq("hit_mem_re", {31'h0, bus.mem_re}, 32'h0);
        check_eq("hit_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("hit_rd", bus.cpu_rd, 32'hDEADBEEF);

        // 3: sub-word loads
        req(1'b0, 1'b1, 32'h0001_0003, 32'h0, 2'b00, 1'b0);
        check_eq("lb_signed", bus.cpu_rd, 32'hFFFFFFDE);
        req(1'b0, 1'b1, 32'h0001_0002, 32'h0, 2'b01, 1'b1);
        check_eq("lhu_hi", bus.cpu_rd, 32'h0000DEAD);
        req(1'b0, 1'b1, 32'h0001_0001, 32'h0, 2'b01, 1'b0);
        check_eq("lh_odd_lo", bus.cpu_rd, 32'hFFFFBEEF);
        req(1'b0, 1'b1, 32'h0001_0001, 32'h0, 2'b00, 1'b1);
        check_eq("lbu_1", bus.cpu_rd, 32'h000000BE);
        req(1'b0, 1'b1, 32'h0001_0003, 32'h0, 2'b11, 1'b0);
        check_eq("size11_word", bus.cpu_rd, 32'hDEADBEEF);

        // 4: sb hit merges into the cached word
        req(1'b1, 1'b1, 32'h0001_0001, 32'h0000_0055, 2'b00, 1'b0);
        check_eq("sb_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("sb_mem_we", {31'h0, bus.mem_we}, 32'h1);
        check_eq("sb_w_addr", bus.mem_w_addr, 32'h0001_0000);
        check_eq("sb_wd", bus.mem_wd, 32'hDEAD55EF);
        check_eq("sb_we_prio_rd", bus.cpu_rd, 32'h0);
        step();
        req(1'b0, 1'b1, 32'h0001_0000, 32'h0, 2'b10, 1'b0);
        check_eq("lw_after_sb", bus.cpu_rd, 32'hDEADBEEF & 32'hFFFF00FF | 32'h00005500);

        // word store miss allocates without a fill
        req(1'b1, 1'b0, 32'h0002_000B, 32'hCAFEF00D, 2'b10, 1'b0);
        check_eq("sw_miss_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("sw_miss_we", {31'h0, bus.mem_we}, 32'h1);
        check_eq("sw_miss_addr", bus.mem_w_addr, 32'h0002_0008);
        check_eq("sw_miss_wd", bus.mem_wd, 32'hCAFEF00D);
        step();
        req(1'b0, 1'b1, 32'h0002_0008, 32'h0, 2'b10, 1'b0);
        check_eq("sw_alloc_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("sw_alloc_rd", bus.cpu_rd, 32'hCAFEF00D);

        // 5: sh miss goes through a fill, then writes the merged word
        ram_word = 32'h11223344;
        req(1'b1, 1'b0, 32'h0001_0406, 32'h0000_BEEF, 2'b01, 1'b0);
        check_eq("sh_miss_stall", {31'h0, bus.stall}, 32'h1);
        check_eq("sh_miss_we", {31'h0, bus.mem_we}, 32'h0);
        step();
        check_eq("sh_fill_re", {31'h0, bus.mem_re}, 32'h1);
        check_eq("sh_fill_we", {31'h0, bus.mem_we}, 32'h0);
        check_eq("sh_fill_addr", bus.mem_r_addr, 32'h0001_0404);
        step();
        check_eq("sh_stall", {31'h0, bus.stall}, 32'h0);
        check_eq("sh_mem_we", {31'h0, bus.mem_we}, 32'h1);
        check_eq("sh_w_addr", bus.mem_w_addr, 32'h0001_0404);
        check_eq("sh_wd", bus.mem_wd, 32'hBEEF3344);
        step();
        req(1'b0, 1'b1, 32'h0001_0006, 32'h0, 2'b10, 1'b0);
        check_eq("alias_miss", {31'h0, bus.stall}, 32'h1);
        step();
        check_eq("alias_fill_re", {31'h0, bus.mem_re}, 32'h1);
        check_eq("alias_fill_addr", bus.mem_r_addr, 32'h0001_0004);

        // 6: reset asserted in FILL abandons the fill
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_fill_re", {31'h0, bus.mem_re}, 32'h0);
        check_eq("rst_fill_stall", {31'h0, bus.stall}, 32'h0);
        step();
        rst_n = 1'b1;
        req(1'b0, 1'b1, 32'h0001_0000, 32'h0, 2'b10, 1'b0);
        check_eq("post_rst_miss", {31'h0, bus.stall}, 32'h1);
        check_eq("post_rst_idle_re", {31'h0, bus.mem_re}, 32'h0);
        check_eq("post_rst_rd", bus.cpu_rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
